// File: rtl/spike_enc_pkg.sv
// Shared types and helpers for the spike event encoder.
// Holds the event record and the round-robin grant function.
package spike_enc_pkg;

   localparam int CH_DEFAULT   = 4;
   localparam int TS_W_DEFAULT = 16;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] ts;
   } spike_event_t;

   function automatic int aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Returns {found, index}: first set request at or after ptr, wrapping at n.
   function automatic logic [4:0] rr_pick(
      input logic [15:0] req,
      input int unsigned n,
      input logic [3:0]  ptr
   );
      logic [4:0]  r;
      int unsigned idx;
      r = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= n) idx = idx - n;
         if (i < n && !r[4] && req[idx[3:0]]) r = {1'b1, idx[3:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO, synchronous active-high reset.
// A push into a full FIFO is accepted only alongside a pop.
module spike_event_fifo #(
   parameter int P_W     = 8,
   parameter int P_DEPTH = 8,
   localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
   localparam int CW = PW + 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_push,
   input  logic [P_W-1:0] i_data,
   input  logic           i_pop,
   output logic [P_W-1:0] o_head,
   output logic [CW-1:0]  o_count,
   output logic           o_full,
   output logic           o_empty
);

   logic [P_W-1:0] mem_q [P_DEPTH];
   logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           do_push, do_pop;

   assign o_empty = (cnt_q == '0);
   assign o_full  = (cnt_q == CW'(P_DEPTH));
   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~o_full | do_pop);
   assign o_head  = mem_q[rd_q];
   assign o_count = cnt_q;

   always_comb begin
      wr_d  = do_push ? wr_q + PW'(1) : wr_q;
      rd_d  = do_pop ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_q] <= i_data;
   end

endmodule

// File: rtl/spike_event_encoder.sv
// Spike edges -> address events: refractory, round-robin arbiter, FIFO.
// Define SPIKE_ENC_TS_EN to build the timestamp counter and ts storage.
module spike_event_encoder
   import spike_enc_pkg::*;
#(
   parameter int P_CH      = CH_DEFAULT,
   parameter int P_DEPTH   = 8,
   parameter int P_TS_W    = TS_W_DEFAULT,
   parameter int P_REFRACT = 4,
   localparam int AW = aw(P_CH),
   localparam int CW = $clog2(P_DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [P_CH-1:0]   i_spike,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [AW-1:0]     o_addr,
   output logic [P_TS_W-1:0] o_ts,
   output logic [CW-1:0]     o_count,
   output logic              o_overflow
);

   localparam int RW = (P_REFRACT > 0) ? $clog2(P_REFRACT + 1) : 1;
`ifdef SPIKE_ENC_TS_EN
   localparam int EW = AW + P_TS_W;
`else
   localparam int EW = AW;
`endif

   logic [P_CH-1:0]         prev_q, prev_d;
   logic [P_CH-1:0]         pend_q, pend_d;
   logic [P_CH-1:0]         rise;
   logic [P_CH-1:0][RW-1:0] refr_q, refr_d;
   logic [AW-1:0]           rr_q, rr_d, gidx;
   logic                    ovf_q, ovf_d;
   logic [4:0]              pick;
   logic                    full, empty, pop, grant;
   logic [EW-1:0]           push_data, head;

`ifdef SPIKE_ENC_TS_EN
   logic [P_TS_W-1:0]            ts_q, ts_d;
   logic [P_CH-1:0][P_TS_W-1:0] tscap_q, tscap_d;
`endif

   assign pop   = ~empty & i_ready;
   assign pick  = rr_pick(16'(pend_q), P_CH, 4'(rr_q));
   assign grant = pick[4] & (~full | pop);
   assign gidx  = AW'(pick[3:0]);
   assign rise  = i_spike & ~prev_q;

   always_comb begin
      prev_d = i_spike;
      pend_d = pend_q;
      refr_d = refr_q;
      ovf_d  = ovf_q;
      rr_d   = rr_q;
`ifdef SPIKE_ENC_TS_EN
      ts_d    = ts_q + P_TS_W'(1);
      tscap_d = tscap_q;
`endif
      if (grant) begin
         pend_d[gidx] = 1'b0;
         rr_d = (gidx == AW'(P_CH - 1)) ? '0 : gidx + AW'(1);
      end
      // Edges inside the refractory window vanish without flagging loss.
      for (int c = 0; c < P_CH; c++) begin
         if (refr_q[c] != '0) refr_d[c] = refr_q[c] - RW'(1);
         if (rise[c] && refr_q[c] == '0) begin
            if (!pend_q[c]) begin
               pend_d[c] = 1'b1;
               refr_d[c] = RW'(P_REFRACT);
`ifdef SPIKE_ENC_TS_EN
               tscap_d[c] = ts_q;
`endif
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prev_q <= '0;
         pend_q <= '0;
         refr_q <= '0;
         rr_q   <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
         refr_q <= refr_d;
         rr_q   <= rr_d;
         ovf_q  <= ovf_d;
      end
   end

`ifdef SPIKE_ENC_TS_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ts_q    <= '0;
         tscap_q <= '0;
      end else begin
         ts_q    <= ts_d;
         tscap_q <= tscap_d;
      end
   end

   assign push_data = {gidx, tscap_q[gidx]};
   assign o_addr    = head[EW-1 -: AW];
   assign o_ts      = head[P_TS_W-1:0];
`else
   assign push_data = gidx;
   assign o_addr    = head;
   assign o_ts      = '0;
`endif

   spike_event_fifo #(
      .P_W     (EW),
      .P_DEPTH (P_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (grant),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_head  (head),
      .o_count (o_count),
      .o_full  (full),
      .o_empty (empty)
   );

   assign o_valid    = ~empty;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: vector table plus corner sequences.
// Timestamp expectations collapse to 0 unless SPIKE_ENC_TS_EN is defined.
module tb_spike_event_encoder;
   import spike_enc_pkg::*;

`ifdef SPIKE_ENC_TS_EN
   localparam logic [31:0] TS_MASK = '1;
`else
   localparam logic [31:0] TS_MASK = '0;
`endif

   typedef struct {
      logic [3:0]  spike;
      logic        v;
      logic [1:0]  a;
      logic [15:0] t;
      logic [3:0]  c;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ready, rst_w;
   logic [3:0]  spike, spike_w;
   logic        valid, ovf, valid_w, ovf_w;
   logic [1:0]  addr, addr_w;
   logic [15:0] ts;
   logic [3:0]  ts_w, cnt, cnt_w;

   int unsigned  ecnt;
   int           n_pass, n_tot;
   vec_t         tbl[$];
   spike_event_t exq[$];

   spike_event_encoder dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_spike    (spike),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_addr     (addr),
      .o_ts       (ts),
      .o_count    (cnt),
      .o_overflow (ovf)
   );

   spike_event_encoder #(.P_TS_W(4)) dut_w (
      .i_clk      (clk),
      .i_rst      (rst_w),
      .i_spike    (spike_w),
      .o_valid    (valid_w),
      .i_ready    (1'b1),
      .o_addr     (addr_w),
      .o_ts       (ts_w),
      .o_count    (cnt_w),
      .o_overflow (ovf_w)
   );

   function automatic logic [31:0] tsx(input logic [31:0] v);
      return v & TS_MASK;
   endfunction

   function automatic vec_t mk(
      input logic [3:0] s, input logic v, input logic [1:0] a,
      input logic [15:0] t, input logic [3:0] c
   );
      vec_t r;
      r.spike = s; r.v = v; r.a = a; r.t = t; r.c = c;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h, want %0h (edge %0d)", nm, act, exp, ecnt);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      ecnt++;
      @(negedge clk);
   endtask

   initial begin
      n_pass = 0; n_tot = 0; ecnt = 0;
      rst = 1'b1; rst_w = 1'b1; ready = 1'b1;
      spike = '0; spike_w = '0;
      @(negedge clk);
      step(); step();
      chk("rst_valid", 32'(valid), 0);
      chk("rst_count", 32'(cnt), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_ts", 32'(ts), 0);
      rst = 1'b0;
      ecnt = 0;

      for (int i = 0; i < 5; i++) tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h4, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 1, 2, 5, 1));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h8, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 1, 3, 8, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'hf, 0, 0, 0, 0));
      tbl.push_back(mk(4'hf, 1, 0, 13, 1));
      tbl.push_back(mk(4'hf, 1, 1, 13, 1));
      tbl.push_back(mk(4'hf, 1, 2, 13, 1));
      tbl.push_back(mk(4'hf, 1, 3, 13, 1));
      tbl.push_back(mk(4'hf, 0, 0, 0, 0));
      tbl.push_back(mk(4'hf, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h2, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 1, 1, 22, 1));
      tbl.push_back(mk(4'h2, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h2, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, 1, 1, 27, 1));
      tbl.push_back(mk(4'h0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         spike = tbl[i].spike;
         step();
         chk("tbl_valid", 32'(valid), 32'(tbl[i].v));
         chk("tbl_count", 32'(cnt), 32'(tbl[i].c));
         chk("tbl_ovf", 32'(ovf), 0);
         if (tbl[i].v) begin
            chk("tbl_addr", 32'(addr), 32'(tbl[i].a));
            chk("tbl_ts", 32'(ts), tsx(32'(tbl[i].t)));
         end
      end

      // Fill with consumer stalled: eight queue, ninth waits as pending.
      ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         spike = 4'(1 << (k % 4));
         exq.push_back({4'(k % 4), 32'(ecnt)});
         step();
         spike = '0;
         step();
      end
      chk("full_count", 32'(cnt), 8);
      chk("full_valid", 32'(valid), 1);
      chk("full_ovf", 32'(ovf), 0);
      ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("drain_valid", 32'(valid), 1);
         chk("drain_addr", 32'(addr), 32'(exq[i].addr));
         chk("drain_ts", 32'(ts), tsx(exq[i].ts));
         step();
      end
      chk("drain_empty", 32'(valid), 0);
      chk("drain_count", 32'(cnt), 0);

      // Overflow: full FIFO, channel 0 pending, then a second ch0 edge.
      ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         spike = 4'(1 << ((k + 1) % 4));
         step();
         spike = '0;
         step();
      end
      repeat (4) step();
      spike = 4'h1;
      step();
      spike = '0;
      chk("pend_only_ovf", 32'(ovf), 0);
      chk("pend_only_cnt", 32'(cnt), 8);
      repeat (4) step();
      spike = 4'h1;
      step();
      spike = '0;
      chk("drop_ovf", 32'(ovf), 1);
      ready = 1'b1;
      repeat (3) step();
      chk("sticky_ovf", 32'(ovf), 1);
      chk("partial_cnt", 32'(cnt), 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", 32'(valid), 0);
      chk("midrst_count", 32'(cnt), 0);
      chk("midrst_ovf", 32'(ovf), 0);
      step();
      chk("postrst_valid", 32'(valid), 0);

      // Timestamp wrap on a 4-bit counter: 15 then 2.
      rst_w = 1'b0;
      repeat (15) step();
      spike_w = 4'h1;
      step();
      spike_w = '0;
      step();
      chk("wrap1_valid", 32'(valid_w), 1);
      chk("wrap1_addr", 32'(addr_w), 0);
      chk("wrap1_ts", 32'(ts_w), tsx(15));
      step();
      spike_w = 4'h2;
      step();
      spike_w = '0;
      step();
      chk("wrap2_valid", 32'(valid_w), 1);
      chk("wrap2_addr", 32'(addr_w), 1);
      chk("wrap2_ts", 32'(ts_w), tsx(2));
      chk("wrap2_cnt", 32'(cnt_w), 1);
      chk("wrap2_ovf", 32'(ovf_w), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
